// File: rtl/store_buffer.sv
// Speculative store buffer: in-order allocate/commit, flush discard, drain to
// data memory over valid/ready, and youngest-match store-to-load forwarding.
module store_buffer #(
  parameter int unsigned STORE_BUFFER_SIZE = 4,
  parameter int unsigned IDX_W             = $clog2(STORE_BUFFER_SIZE)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         alloc_valid_i,
  input  logic [31:0]                  alloc_addr_i,
  input  logic [31:0]                  alloc_data_i,
  input  logic [1:0]                   alloc_size_i,
  output logic [IDX_W-1:0]             alloc_idx_o,
  output logic                         full_o,
  output logic                         empty_o,
  input  logic                         commit_valid_i,
  input  logic [IDX_W-1:0]             commit_idx_i,
  input  logic [STORE_BUFFER_SIZE-1:0] discard_i,
  output logic                         mem_req_valid_o,
  output logic [31:0]                  mem_req_addr_o,
  output logic [31:0]                  mem_req_data_o,
  output logic [1:0]                   mem_req_size_o,
  input  logic                         mem_req_ready_i,
  input  logic                         ld_check_valid_i,
  input  logic [31:0]                  ld_addr_i,
  input  logic [1:0]                   ld_size_i,
  output logic                         ld_hit_o,
  output logic [31:0]                  ld_data_o,
  output logic                         ld_conflict_o
);

  localparam logic [IDX_W:0] FULL_CNT = {1'b1, {IDX_W{1'b0}}};

  logic [STORE_BUFFER_SIZE-1:0] valid_q, valid_d, comm_q, comm_d;
  logic [31:0]                  addr_q [STORE_BUFFER_SIZE];
  logic [31:0]                  data_q [STORE_BUFFER_SIZE];
  logic [1:0]                   size_q [STORE_BUFFER_SIZE];
  logic [IDX_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]               count_q, count_d, n_comm;
  logic                         drain, any_discard, do_alloc;

  logic [3:0]                   ld_mask, st_mask;
  logic                         fwd_found;
  logic [IDX_W-1:0]             fwd_idx, scan_idx;
  logic [31:0]                  fwd_lane;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_mask = 4'b0001 << off;
      2'd1:    byte_mask = 4'b0011 << off;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 32'h0000_00FF;
      2'd1:    size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  assign alloc_idx_o = tail_q;
  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == '0);

  assign mem_req_valid_o = valid_q[head_q] & comm_q[head_q];
  assign mem_req_addr_o  = mem_req_valid_o ? addr_q[head_q] : '0;
  assign mem_req_data_o  = mem_req_valid_o ? data_q[head_q] : '0;
  assign mem_req_size_o  = mem_req_valid_o ? size_q[head_q] : '0;

  assign drain       = mem_req_valid_o & mem_req_ready_i;
  assign any_discard = |discard_i;
  assign do_alloc    = alloc_valid_i & ~full_o & ~any_discard;

  always_comb begin
    valid_d = valid_q;
    comm_d  = comm_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    n_comm  = '0;

    if (commit_valid_i && valid_q[commit_idx_i]) comm_d[commit_idx_i] = 1'b1;

    // Applied after commit so a same-cycle commit protects its entry.
    for (int unsigned i = 0; i < STORE_BUFFER_SIZE; i++) begin
      if (discard_i[IDX_W'(i)] && !comm_d[IDX_W'(i)]) valid_d[IDX_W'(i)] = 1'b0;
    end

    if (drain) begin
      valid_d[head_q] = 1'b0;
      comm_d[head_q]  = 1'b0;
      head_d          = head_q + IDX_W'(1);
    end

    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      comm_d[tail_q]  = 1'b0;
      tail_d          = tail_q + IDX_W'(1);
    end

    if (any_discard) begin
      for (int unsigned i = 0; i < STORE_BUFFER_SIZE; i++) begin
        n_comm = n_comm + (IDX_W+1)'(valid_d[IDX_W'(i)] & comm_d[IDX_W'(i)]);
      end
      tail_d  = head_d + n_comm[IDX_W-1:0];
      count_d = n_comm;
    end else begin
      case ({do_alloc, drain})
        2'b10:   count_d = count_q + (IDX_W+1)'(1);
        2'b01:   count_d = count_q - (IDX_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      comm_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      comm_q  <= comm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      addr_q[tail_q] <= alloc_addr_i;
      data_q[tail_q] <= alloc_data_i;
      size_q[tail_q] <= alloc_size_i;
    end
  end

  // Oldest-to-youngest scan; the last overlapping entry seen is the youngest.
  always_comb begin
    ld_mask   = byte_mask(ld_size_i, ld_addr_i[1:0]);
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < STORE_BUFFER_SIZE; k++) begin
      scan_idx = head_q + IDX_W'(k);
      if (valid_q[scan_idx] && (addr_q[scan_idx][31:2] == ld_addr_i[31:2]) &&
          |(byte_mask(size_q[scan_idx], addr_q[scan_idx][1:0]) & ld_mask)) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
    st_mask  = byte_mask(size_q[fwd_idx], addr_q[fwd_idx][1:0]);
    fwd_lane = data_q[fwd_idx] << {addr_q[fwd_idx][1:0], 3'b000};

    ld_hit_o      = 1'b0;
    ld_conflict_o = 1'b0;
    ld_data_o     = '0;
    if (ld_check_valid_i && fwd_found) begin
      if ((st_mask & ld_mask) == ld_mask) begin
        ld_hit_o  = 1'b1;
        ld_data_o = (fwd_lane >> {ld_addr_i[1:0], 3'b000}) & size_mask(ld_size_i);
      end else begin
        ld_conflict_o = 1'b1;
      end
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Holds speculative stores between execute/writeback and data memory. Each store gets an entry index when it leaves the memory stage; the ROB later commits that index in program order, or discards it on a flush. Committed entries drain to the data-memory write port in allocation order over a valid/ready handshake. Younger loads are checked against buffered stores, and either receive forwarded data or are told to stall.

## Interface
Parameters:
- STORE_BUFFER_SIZE, 4 (package value), number of entries; power of two, at least 2.
- IDX_W, $clog2(STORE_BUFFER_SIZE), entry index width (store_buffer_idx_t).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- alloc_valid_i  in  1  memory stage presents a store this cycle.
- alloc_addr_i  in  32  store byte address.
- alloc_data_i  in  32  store data, right-aligned.
- alloc_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word.
- alloc_idx_o  out  IDX_W  index the next allocation receives; equals tail_q.
- full_o  out  1  all entries occupied.
- empty_o  out  1  no entries occupied.
- commit_valid_i  in  1  ROB commits a store this cycle.
- commit_idx_i  in  IDX_W  entry being committed.
- discard_i  in  STORE_BUFFER_SIZE  one bit per entry to invalidate (flush).
- mem_req_valid_o  out  1  drain request valid.
- mem_req_addr_o  out  32  drain address.
- mem_req_data_o  out  32  drain data.
- mem_req_size_o  out  2  drain size.
- mem_req_ready_i  in  1  memory accepts the drain request.
- ld_check_valid_i  in  1  a load is probing the buffer.
- ld_addr_i  in  32  load byte address.
- ld_size_i  in  2  load size.
- ld_hit_o  out  1  forward is possible; ld_data_o is valid.
- ld_data_o  out  32  forwarded data, right-aligned.
- ld_conflict_o  out  1  overlapping store cannot be forwarded; load must stall.

## Operation
- State:
  - Circular array of entries, each holding {valid, committed, addr, data, size}.
  - head_q and tail_q pointers, both IDX_W bits wide, wrapping modulo STORE_BUFFER_SIZE.
  - count_q, IDX_W+1 bits wide.
- Allocation:
  - If alloc_valid_i && !full_o, write the entry at tail_q with valid=1 and committed=0, then advance tail.
  - If the buffer is full, the allocation is ignored and full_o tells the producer to stall.
- Commit:
  - If commit_valid_i and the entry is valid, set committed=1.
  - Commit to an invalid entry is ignored.
  - Commits arrive in order, so committed entries always form a contiguous run starting at head.
- Drain:
  - mem_req_valid_o = entry[head].valid && entry[head].committed.
  - Address, data and size come straight from the head entry.
  - On valid && ready, clear the head entry and advance head. At most one drain per cycle.
- Discard:
  - For each set bit, clear valid on an uncommitted entry. Bits on committed entries are ignored.
  - If any bit is set, recompute tail_d = head_d + number of committed entries remaining after this cycle's drain, and set count_d to match.
  - An allocation in the same cycle as any discard bit is dropped, because it belongs to the flushed path.
- Simultaneous events:
  - Commit and discard on the same index in the same cycle: commit wins.
  - Drain and allocation in the same cycle: count is unchanged.
  - Allocation while full is ignored even if a drain happens in the same cycle; the slot is usable next cycle.
- Forwarding (combinational, only when ld_check_valid_i):
  - Scan from tail-1 back to head and take the youngest valid entry whose byte range overlaps the load's range.
  - Word-aligned comparison: overlap means the same addr[31:2] and intersecting byte masks.
  - If the entry's byte mask covers the load's mask, set ld_hit_o=1 and ld_data_o = store data shifted to the load's byte offset.
  - Otherwise set ld_conflict_o=1.
  - With no overlapping entry, or when ld_check_valid_i is low, both flags and ld_data_o are 0.
  - Committed entries that have not yet drained still forward.
- Width and arithmetic rules:
  - Pointers wrap naturally at IDX_W bits.
  - Byte mask: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111.
  - Misaligned stores are not handled here; the upstream stage has already raised an exception for them.

## Timing
- Reset (async, while rstn_i=0):
  - All entries invalid, head=tail=0, count=0.
  - empty_o=1, full_o=0, alloc_idx_o=0.
  - mem_req_valid_o=0, mem_req_* data fields 0, ld_hit_o=0, ld_conflict_o=0, ld_data_o=0.
- Reset asserted mid-drain drops the request immediately, even if ready was high.
- Latency:
  - An allocation is visible to forwarding in the next cycle.
  - A commit in cycle N makes mem_req_valid_o high in cycle N+1 at the earliest.
  - With ready held high, back-to-back committed entries drain one per cycle.
- Handshake: while mem_req_valid_o=1 and ready=0, addr, data and size hold stable. A discard never lowers a valid request, since only committed entries drain.
- full_o and empty_o come directly from count_q, with no combinational path from inputs.

## Test plan
- Allocate word stores 0x100 and 0x104 (idx 0 and 1), commit both, ready=1 → drains to 0x100 then 0x104 in consecutive cycles; empty_o=1 after.
- SIZE=4: allocate 4 stores → full_o=1; 5th alloc ignored, alloc_idx_o stays 0. Commit idx0 and drain → full_o=0 next cycle, 5th alloc then gets idx 0.
- Allocate idx 0–2, commit idx0, discard=4'b0110 → tail=1, count=1; only 0x... from idx0 drains; next alloc gets idx 1.
- Store word 0xDEADBEEF at 0x200, load byte 0x201 → ld_hit_o=1, ld_data_o=0x000000BE. Store byte at 0x300, load word 0x300 → ld_conflict_o=1.
- Committed head with ready=0 for 3 cycles → request fields constant; accepted on cycle 4; head advances.
- rstn_i low during valid request → all outputs return to reset values asynchronously; after release, empty_o=1 and alloc_idx_o=0.
